// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and default widths for pipeline stage registers
package pipe_pkg;

    // Occupancy of the skid-buffered stage: nothing, main only, main plus skid
    typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;

    // Default bundle widths for an RV32 pipeline boundary
    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage with flush, optional skid buffer and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              in_xfer;
    logic              out_xfer;
    logic [CTRL_W-1:0] ctrl_q;

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    // Bubbles must never carry live write-enables downstream
    assign ctrl_o = ctrl_q & {CTRL_W{valid_o}};

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t       state;
            logic              ready_q;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // ready_o comes straight from a flop so ready_i never reaches it combinationally
            assign ready_o = ready_q;
            assign valid_o = (state != PS_EMPTY);

            // Two-entry FSM: main always feeds the output, skid absorbs the one item
            // that arrives while ready_q is still high during a downstream stall
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    state     <= PS_EMPTY;
                    ready_q   <= 1'b1;
                    data_o    <= '0;
                    ctrl_q    <= '0;
                    skid_data <= '0;
                    skid_ctrl <= '0;
                end else if (flush_i) begin
                    state   <= PS_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    case (state)
                        PS_EMPTY: begin
                            if (in_xfer) begin
                                data_o <= data_i;
                                ctrl_q <= ctrl_i;
                                state  <= PS_BUSY;
                            end
                        end
                        PS_BUSY: begin
                            if (in_xfer && out_xfer) begin
                                data_o <= data_i;
                                ctrl_q <= ctrl_i;
                            end else if (in_xfer) begin
                                skid_data <= data_i;
                                skid_ctrl <= ctrl_i;
                                state     <= PS_FULL;
                                ready_q   <= 1'b0;
                            end else if (out_xfer) begin
                                state <= PS_EMPTY;
                            end
                        end
                        PS_FULL: begin
                            if (out_xfer) begin
                                data_o  <= skid_data;
                                ctrl_q  <= skid_ctrl;
                                state   <= PS_BUSY;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= PS_EMPTY;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic valid_q;

            assign valid_o = valid_q;
            assign ready_o = ~valid_q | ready_i;

            // Single register: load on accept, drop valid once drained, flush kills valid only
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    valid_q <= 1'b0;
                    data_o  <= '0;
                    ctrl_q  <= '0;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (in_xfer) begin
                    valid_q <= 1'b1;
                    data_o  <= data_i;
                    ctrl_q  <= ctrl_i;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc    (valid_o & ~ready_i),
        .cnt    (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in skid and single-register modes
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v1_i, r1_o, f1, v1_o, rd1_i;
    logic [31:0] d1_i, d1_o;
    logic [15:0] c1_i, c1_o, s1;

    logic        v0_i, r0_o, f0, v0_o, rd0_i;
    logic [31:0] d0_i, d0_o;
    logic [15:0] c0_i, c0_o;
    logic [3:0]  s0;

    int errors = 0;
    int checks = 0;

    logic [47:0] q1[$];
    logic [47:0] q0[$];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(16)) dut (
        .clk_i(clk), .reset_i(rst), .valid_i(v1_i), .ready_o(r1_o), .data_i(d1_i), .ctrl_i(c1_i),
        .flush_i(f1), .valid_o(v1_o), .ready_i(rd1_i), .data_o(d1_o), .ctrl_o(c1_o), .stall_cnt_o(s1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(4)) dut0 (
        .clk_i(clk), .reset_i(rst), .valid_i(v0_i), .ready_o(r0_o), .data_i(d0_i), .ctrl_i(c0_i),
        .flush_i(f0), .valid_o(v0_o), .ready_i(rd0_i), .data_o(d0_o), .ctrl_o(c0_o), .stall_cnt_o(s0)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v1_i = 0; f1 = 0; rd1_i = 0; d1_i = '0; c1_i = '0;
        v0_i = 0; f0 = 0; rd0_i = 0; d0_i = '0; c0_i = '0;
        #1;
        checks++;
        if ({v1_o, r1_o, d1_o, c1_o, s1} !== {1'b0, 1'b1, 32'h0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_skid got=%h exp=%h", {v1_o, r1_o, d1_o, c1_o, s1}, {1'b0, 1'b1, 32'h0, 16'h0, 16'h0});
        end
        checks++;
        if ({v0_o, r0_o, d0_o, c0_o, s0} !== {1'b0, 1'b1, 32'h0, 16'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_single got=%h exp=%h", {v0_o, r0_o, d0_o, c0_o, s0}, {1'b0, 1'b1, 32'h0, 16'h0, 4'h0});
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last = -1;
        int got = 0;
        logic [47:0] exp;
        rd1_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            v1_i = (c < 8);
            d1_i = 32'(c + 1);
            c1_i = 16'(c + 257);
            @(negedge clk);
            if (v1_o && rd1_i) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected got=%h exp=none", d1_o);
                end else begin
                    exp = q1.pop_front();
                    if ({c1_o, d1_o} !== exp) begin
                        errors++;
                        $display("FAIL b2b_data got=%h exp=%h", {c1_o, d1_o}, exp);
                    end
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            if (v1_i && r1_o) q1.push_back({c1_i, d1_i});
            next_cycle();
        end
        checks++;
        if (got !== 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
        checks++;
        if (first !== 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=1", first); end
        checks++;
        if (last !== 8) begin errors++; $display("FAIL b2b_throughput got=%0d exp=8", last); end
    endtask

    task automatic test_backpressure();
        int idx = 1;
        int acc = 0;
        int popped = 0;
        int c1st = -1;
        logic r_at[4];
        logic r_hist[8];
        logic [47:0] exp;
        rd1_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            v1_i = 1'b1;
            d1_i = 32'(idx);
            c1_i = 16'(idx + 512);
            @(negedge clk);
            r_at[c] = r1_o;
            if (v1_i && r1_o) begin
                q1.push_back({c1_i, d1_i});
                idx++;
                acc++;
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (acc !== 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
        checks++;
        if ({r_at[1], r_at[2], r_at[3]} !== 3'b100) begin
            errors++;
            $display("FAIL bp_ready_drop got=%b exp=100", {r_at[1], r_at[2], r_at[3]});
        end
        checks++;
        if ({v1_o, d1_o, s1} !== {1'b1, 32'd1, 16'd3}) begin
            errors++;
            $display("FAIL bp_full_state got=%h exp=%h", {v1_o, d1_o, s1}, {1'b1, 32'd1, 16'd3});
        end
        rd1_i = 1'b1;
        #1;
        checks++;
        if (r1_o !== 1'b0) begin errors++; $display("FAIL bp_ready_registered got=%b exp=0", r1_o); end
        rd1_i = 1'b0;
        next_cycle();
        rd1_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            v1_i = (idx <= 3);
            d1_i = 32'(idx);
            c1_i = 16'(idx + 512);
            @(negedge clk);
            r_hist[c] = r1_o;
            if (v1_o && rd1_i) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL bp_unexpected got=%h exp=none", d1_o);
                end else begin
                    exp = q1.pop_front();
                    if ({c1_o, d1_o} !== exp) begin
                        errors++;
                        $display("FAIL bp_order got=%h exp=%h", {c1_o, d1_o}, exp);
                    end
                end
                popped++;
                if (c1st < 0) c1st = c;
            end
            if (v1_i && r1_o) begin
                q1.push_back({c1_i, d1_i});
                idx++;
            end
            next_cycle();
        end
        checks++;
        if (popped !== 3) begin errors++; $display("FAIL bp_drained got=%0d exp=3", popped); end
        checks++;
        if (c1st !== 0 || {r_hist[0], r_hist[1]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_ready_return got=%0d/%b exp=0/01", c1st, {r_hist[0], r_hist[1]});
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        rd1_i = 1'b0;
        v1_i = 1'b1; d1_i = 32'hA1; c1_i = 16'h00FF;
        next_cycle();
        d1_i = 32'hA2;
        next_cycle();
        d1_i = 32'h55; c1_i = 16'h00F0; f1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({v1_o, r1_o, c1_o} !== {1'b1, 1'b0, 16'h00FF}) begin
            errors++;
            $display("FAIL flush_pre got=%h exp=%h", {v1_o, r1_o, c1_o}, {1'b1, 1'b0, 16'h00FF});
        end
        next_cycle();
        f1 = 1'b0; v1_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({v1_o, r1_o, c1_o, d1_o} !== {1'b0, 1'b1, 16'h0, 32'hA1}) begin
            errors++;
            $display("FAIL flush_full got=%h exp=%h", {v1_o, r1_o, c1_o, d1_o}, {1'b0, 1'b1, 16'h0, 32'hA1});
        end
        rd1_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (v1_o) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_55 got=%0d exp=0", seen); end
        next_cycle();
        rd1_i = 1'b0; v1_i = 1'b1; d1_i = 32'h66; c1_i = 16'h0F0F;
        next_cycle();
        d1_i = 32'h77; rd1_i = 1'b1; f1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({v1_o, r1_o} !== 2'b11) begin errors++; $display("FAIL flush_busy_pre got=%b exp=11", {v1_o, r1_o}); end
        next_cycle();
        f1 = 1'b0; v1_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (v1_o) seen++;
        end
        checks++;
        if (seen !== 0 || d1_o !== 32'h66) begin
            errors++;
            $display("FAIL flush_busy got=%0d/%h exp=0/66", seen, d1_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        rd1_i = 1'b0;
        v1_i = 1'b1; d1_i = 32'hDEADBEEF; c1_i = 16'h1234;
        next_cycle();
        d1_i = 32'hCAFE0001;
        next_cycle();
        v1_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({v1_o, r1_o, d1_o} !== {1'b1, 1'b0, 32'hDEADBEEF} || s1 == 16'h0) begin
            errors++;
            $display("FAIL rstmid_pre got=%h/%0d exp=%h/nonzero", {v1_o, r1_o, d1_o}, s1, {1'b1, 1'b0, 32'hDEADBEEF});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({v1_o, r1_o, d1_o, c1_o, s1} !== {1'b1 ^ 1'b1, 1'b1, 32'h0, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL rstmid_async got=%h exp=%h", {v1_o, r1_o, d1_o, c1_o, s1}, {1'b0, 1'b1, 32'h0, 16'h0, 16'h0});
        end
        next_cycle();
        rst = 1'b0;
        q1.delete();
        @(negedge clk);
        checks++;
        if ({v1_o, r1_o} !== 2'b01) begin errors++; $display("FAIL rstmid_after got=%b exp=01", {v1_o, r1_o}); end
        next_cycle();
    endtask

    task automatic test_counter();
        logic [3:0] exp;
        v0_i = 1'b1; d0_i = 32'h99; c0_i = 16'h00AB; rd0_i = 1'b0;
        @(negedge clk);
        if (v0_i && r0_o) q0.push_back({c0_i, d0_i});
        next_cycle();
        v0_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp = (k > 15) ? 4'd15 : 4'(k);
            checks++;
            if (s0 !== exp) begin errors++; $display("FAIL cnt_k%0d got=%0d exp=%0d", k, s0, exp); end
            next_cycle();
        end
    endtask

    task automatic test_comb_ready();
        @(negedge clk);
        rd0_i = 1'b1;
        #1;
        checks++;
        if ({v0_o, r0_o} !== 2'b11) begin errors++; $display("FAIL comb_ready_hi got=%b exp=11", {v0_o, r0_o}); end
        rd0_i = 1'b0;
        #1;
        checks++;
        if ({v0_o, r0_o} !== 2'b10) begin errors++; $display("FAIL comb_ready_lo got=%b exp=10", {v0_o, r0_o}); end
        next_cycle();
    endtask

    task automatic test_random();
        logic h1 = 1'b0;
        logic h0 = 1'b0;
        int n1 = 0;
        int n0 = 0;
        logic [47:0] exp;
        for (int c = 0; c < 90; c++) begin
            if (c >= 80) begin
                v1_i = 1'b0; v0_i = 1'b0; rd1_i = 1'b1; rd0_i = 1'b1;
            end else begin
                if (!h1) begin v1_i = ($urandom_range(0, 3) != 0); d1_i = $urandom; c1_i = 16'($urandom); end
                if (!h0) begin v0_i = ($urandom_range(0, 3) != 0); d0_i = $urandom; c0_i = 16'($urandom); end
                rd1_i = ($urandom_range(0, 3) != 0);
                rd0_i = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (v1_o && rd1_i) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++; $display("FAIL rnd_skid_unexpected got=%h exp=none", d1_o);
                end else begin
                    exp = q1.pop_front();
                    if ({c1_o, d1_o} !== exp) begin errors++; $display("FAIL rnd_skid got=%h exp=%h", {c1_o, d1_o}, exp); end
                end
                n1++;
            end
            if (v0_o && rd0_i) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++; $display("FAIL rnd_single_unexpected got=%h exp=none", d0_o);
                end else begin
                    exp = q0.pop_front();
                    if ({c0_o, d0_o} !== exp) begin errors++; $display("FAIL rnd_single got=%h exp=%h", {c0_o, d0_o}, exp); end
                end
                n0++;
            end
            if (v1_i && r1_o) q1.push_back({c1_i, d1_i});
            if (v0_i && r0_o) q0.push_back({c0_i, d0_i});
            h1 = v1_i && !r1_o;
            h0 = v0_i && !r0_o;
            next_cycle();
        end
        checks++;
        if (q1.size() != 0 || n1 < 10) begin errors++; $display("FAIL rnd_skid_drain got=%0d/%0d exp=0/>=10", q1.size(), n1); end
        checks++;
        if (q0.size() != 0 || n0 < 10) begin errors++; $display("FAIL rnd_single_drain got=%0d/%0d exp=0/>=10", q0.size(), n0); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_counter();
        test_comb_ready();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised valid/ready pipeline stage register, the generic successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the RV32 pipeline. It carries an opaque data bundle and a control bundle between adjacent stages. It adds handshake-based stalling, synchronous flush with bubble insertion, an optional skid buffer that breaks the combinational ready path, and a saturating stall counter. Every pipeline boundary instantiates it with its own widths.

## Interface
Parameters:
- DATA_W, 128, width of the datapath bundle (operands, PC values, immediates)
- CTRL_W, 16, width of the control bundle (regWrite, MemWrite, ALU op, …); forced to zero in bubbles
- SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  upstream holds a valid item
- ready_o  out  1  stage can accept an item this cycle
- data_i  in  DATA_W  upstream data bundle
- ctrl_i  in  CTRL_W  upstream control bundle
- flush_i  in  1  synchronous kill of all held items (branch/jump redirect)
- valid_o  out  1  stage presents a valid item
- ready_i  in  1  downstream accepts this cycle
- data_o  out  DATA_W  held data bundle
- ctrl_o  out  CTRL_W  held control bundle, zero whenever valid_o=0
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0, saturating

## Operation
- Input transfer occurs when valid_i & ready_o at the clock edge. Output transfer occurs when valid_o & ready_i at the clock edge.
- SKID=0: one main register. ready_o = ~valid_o | ready_i. On an input transfer, the main register loads and valid_o=1. On an output transfer without an input transfer, valid_o goes to 0.
- SKID=1: main register plus skid register. FSM states are EMPTY, BUSY and FULL. ready_o is 1 exactly in EMPTY and BUSY, and is driven from a flop.
  - EMPTY: input transfer → BUSY (main loads).
  - BUSY: input and output → BUSY (main reloads). Input only → FULL (skid loads). Output only → EMPTY. Neither → BUSY.
  - FULL: output → BUSY (skid moves to main). Otherwise stay in FULL. No input is possible.
  - valid_o = state != EMPTY. Outputs always come from main; order is preserved.
- flush_i has the highest priority:
  - Next state is EMPTY (SKID=0: valid_o←0).
  - Any input transferred in the same cycle is discarded.
  - An output transfer in the same cycle still counts as completed.
  - Data registers hold their value (no enable toggling); the control path is gated by valid.
- ctrl_o = ctrl_reg & {CTRL_W{valid_o}}. Bubbles never assert write-enables.
- stall_cnt_o increments by 1 each cycle valid_o & ~ready_i. It holds at 2^CNT_W−1 and is cleared only by reset.
- Reset (asynchronous, at any time including mid-transfer): state EMPTY, valid_o=0, ready_o=1 (SKID=1; for SKID=0 it follows from valid_o=0), data_o=0, ctrl_o=0, stall_cnt_o=0, skid register=0.

## Timing
- Latency is 1 cycle from input transfer to valid_o in both modes.
- Throughput is 1 item/cycle sustained while ready_i=1.
- SKID=0 has a combinational path ready_i→ready_o. SKID=1 has none: ready_o depends only on state.
- SKID=1: ready_o drops in the cycle after the first stalled input transfer. At most one extra item is absorbed.
- SKID=1, FULL with ready_i=1: ready_o returns 1 one cycle later. The skid item appears on data_o that same cycle.
- Flush takes effect at the edge where it is sampled: valid_o=0 and ctrl_o=0 in the following cycle.
- Release of reset is synchronised externally; the block makes no assumption about deassertion alignment beyond clk_i.

## Structure
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;
  - default width localparams (RV32 DATA_W/CTRL_W per boundary).
- A single generate split on SKID selects the register topology.
- The saturating counter is a natural sub-module: sat_counter (parameter W; inputs inc, clk_i, reset_i).

## Test plan
- Reset mid-stream: assert reset_i with data 0xDEADBEEF in FULL. valid_o, ctrl_o, data_o and stall_cnt_o must go to 0 immediately, without waiting for a clock edge.
- Back-to-back flow, SKID=1: send items 1..8 with ready_i=1. data_o shows 1..8 on consecutive cycles, 1 cycle after each input.
- Backpressure, SKID=1: send 1,2,3 with ready_i held 0.
  - State reaches FULL holding 1 and 2; ready_o=0 from cycle 2; item 3 is not accepted.
  - Releasing ready_i outputs 1, 2, then 3, in order.
- Flush: FULL with ctrl 0x00FF, assert flush_i together with a valid input 0x55. Next cycle valid_o=0, ctrl_o=0x0000, and 0x55 never appears.
- Counter: SKID=0, CNT_W=4, valid_o=1, ready_i=0 for 20 cycles. stall_cnt_o counts to 15 and holds at 15.
- SKID=0 combinational ready: valid_o=1, toggle ready_i. ready_o follows ready_i in the same cycle.
